// File: rtl/mdu.sv
// Multiply/divide unit with architectural HI/LO registers.
// A mult/div runs for a fixed number of busy cycles, after which HI/LO take the captured result.
module mdu #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  MDOp,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        Start,
    output logic        Busy,
    output logic [31:0] HI,
    output logic [31:0] LO,
    output logic [31:0] MDOut
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] RUN  = 1'b1;

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MFHI  = 4'd5;
    localparam logic [3:0] OP_MFLO  = 4'd6;
    localparam logic [3:0] OP_MTHI  = 4'd7;
    localparam logic [3:0] OP_MTLO  = 4'd8;

    // Returns {valid, hi, lo}; valid is low for a divide by zero so HI/LO are left alone.
    function automatic logic [64:0] calc_result(input logic [3:0] op,
                                                input logic [31:0] a,
                                                input logic [31:0] b);
        logic signed [63:0] sa;
        logic signed [63:0] sb;
        logic signed [31:0] sq;
        logic signed [31:0] sr;
        logic [64:0]        res;
        sa  = $signed({{32{a[31]}}, a});
        sb  = $signed({{32{b[31]}}, b});
        sq  = 32'sd0;
        sr  = 32'sd0;
        res = 65'd0;
        case (op)
            OP_MULT:  res = {1'b1, sa * sb};
            OP_MULTU: res = {1'b1, {32'd0, a} * {32'd0, b}};
            OP_DIV: begin
                if (b != 32'd0) begin
                    sq  = $signed(a) / $signed(b);
                    sr  = $signed(a) % $signed(b);
                    res = {1'b1, sr, sq};
                end else begin
                    res = 65'd0;
                end
            end
            OP_DIVU: begin
                if (b != 32'd0) begin
                    res = {1'b1, a % b, a / b};
                end else begin
                    res = 65'd0;
                end
            end
            default: res = 65'd0;
        endcase
        return res;
    endfunction

    logic [0:0]       state_r;
    logic [CNT_W-1:0] cnt_r;
    logic [63:0]      res_r;
    logic             res_valid_r;
    logic [31:0]      hi_r;
    logic [31:0]      lo_r;
    logic             start_s;
    logic             is_mult_s;
    logic             done_s;
    logic [64:0]      calc_s;
    logic [31:0]      md_out_s;

    assign Busy      = (state_r == RUN);
    assign is_mult_s = (MDOp == OP_MULT) || (MDOp == OP_MULTU);
    assign start_s   = (MDOp >= OP_MULT) && (MDOp <= OP_DIVU) && !Busy;
    assign done_s    = (state_r == RUN) && (cnt_r == CNT_W'(1));
    assign calc_s    = calc_result(MDOp, A, B);
    assign Start     = start_s;
    assign HI        = hi_r;
    assign LO        = lo_r;
    assign MDOut     = md_out_s;

    // IDLE/RUN control and busy-cycle down-counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= IDLE;
            cnt_r   <= '0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (start_s) begin
                        state_r <= RUN;
                        cnt_r   <= is_mult_s ? CNT_W'(MULT_CYCLES) : CNT_W'(DIV_CYCLES);
                    end
                end
                RUN: begin
                    cnt_r <= cnt_r - CNT_W'(1);
                    if (done_s) begin
                        state_r <= IDLE;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    cnt_r   <= '0;
                end
            endcase
        end
    end

    // Result is computed from the operands present at Start, so later A/B changes cannot leak in.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            res_r       <= 64'd0;
            res_valid_r <= 1'b0;
        end else if (start_s) begin
            res_r       <= calc_s[63:0];
            res_valid_r <= calc_s[64];
        end
    end

    // Architectural HI/LO: completion update, or mthi/mtlo while idle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hi_r <= 32'd0;
            lo_r <= 32'd0;
        end else if (done_s) begin
            if (res_valid_r) begin
                hi_r <= res_r[63:32];
                lo_r <= res_r[31:0];
            end
        end else if (state_r == IDLE) begin
            if (MDOp == OP_MTHI) begin
                hi_r <= A;
            end else if (MDOp == OP_MTLO) begin
                lo_r <= A;
            end
        end
    end

    // mfhi/mflo read path; zero for every other op or while busy.
    always_comb begin
        md_out_s = 32'd0;
        if (!Busy) begin
            case (MDOp)
                OP_MFHI: md_out_s = hi_r;
                OP_MFLO: md_out_s = lo_r;
                default: md_out_s = 32'd0;
            endcase
        end else begin
            md_out_s = 32'd0;
        end
    end

endmodule

// File: tb/tb_mdu.sv
// Directed testbench for mdu: timing of Start/Busy, arithmetic results, moves, guards and reset abort.
module tb_mdu;

    logic        clk;
    logic        reset;
    logic [3:0]  MDOp;
    logic [31:0] A;
    logic [31:0] B;
    logic        Start;
    logic        Busy;
    logic [31:0] HI;
    logic [31:0] LO;
    logic [31:0] MDOut;

    int vectors;
    int miscompares;

    mdu #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk   (clk),
        .reset (reset),
        .MDOp  (MDOp),
        .A     (A),
        .B     (B),
        .Start (Start),
        .Busy  (Busy),
        .HI    (HI),
        .LO    (LO),
        .MDOut (MDOut)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        MDOp  = 4'd0;
        A     = 32'd0;
        B     = 32'd0;
        #3;
        vectors++;
        if (Busy !== 1'b0 || HI !== 32'd0 || LO !== 32'd0) begin
            miscompares++;
            $display("FAIL reset_async: busy=%b hi=%h lo=%h, need 0/0/0", Busy, HI, LO);
        end
        repeat (2) tick();
        reset = 1'b0;
        #1;
        vectors++;
        if (Busy !== 1'b0 || Start !== 1'b0 || MDOut !== 32'd0 || HI !== 32'd0 || LO !== 32'd0) begin
            miscompares++;
            $display("FAIL reset_state: busy=%b start=%b mdout=%h hi=%h lo=%h, need all 0",
                     Busy, Start, MDOut, HI, LO);
        end
    endtask

    task automatic test_mult();
        MDOp = 4'd1; A = 32'hFFFF_FFFD; B = 32'd5;
        #1;
        vectors++;
        if (Start !== 1'b1) begin
            miscompares++;
            $display("FAIL mult_start: start=%b need 1", Start);
        end
        tick();
        MDOp = 4'd0;
        for (int i = 1; i <= 5; i++) begin
            vectors++;
            if (Busy !== 1'b1 || HI !== 32'd0 || LO !== 32'd0) begin
                miscompares++;
                $display("FAIL mult_busy c%0d: busy=%b hi=%h lo=%h, need 1/0/0", i, Busy, HI, LO);
            end
            tick();
        end
        vectors++;
        if (Busy !== 1'b0 || HI !== 32'hFFFF_FFFF || LO !== 32'hFFFF_FFF1) begin
            miscompares++;
            $display("FAIL mult_done: busy=%b hi=%h lo=%h, need 0/ffffffff/fffffff1", Busy, HI, LO);
        end
    endtask

    task automatic test_multu();
        MDOp = 4'd2; A = 32'hFFFF_FFFF; B = 32'd2;
        tick();
        MDOp = 4'd0;
        repeat (4) tick();
        vectors++;
        if (Busy !== 1'b1 || HI !== 32'hFFFF_FFFF) begin
            miscompares++;
            $display("FAIL multu_c5: busy=%b hi=%h, need 1/ffffffff", Busy, HI);
        end
        tick();
        MDOp = 4'd6;
        #1;
        vectors++;
        if (Busy !== 1'b0 || HI !== 32'h0000_0001 || LO !== 32'hFFFF_FFFE || MDOut !== 32'hFFFF_FFFE) begin
            miscompares++;
            $display("FAIL multu_done: busy=%b hi=%h lo=%h mdout=%h, need 0/00000001/fffffffe/fffffffe",
                     Busy, HI, LO, MDOut);
        end
    endtask

    task automatic test_div();
        logic [31:0] av [2];
        logic [31:0] bv [2];
        logic [3:0]  ov [2];
        logic [31:0] eh [2];
        logic [31:0] el [2];
        av[0] = 32'hFFFF_FFF9; bv[0] = 32'd2; ov[0] = 4'd3; eh[0] = 32'hFFFF_FFFF; el[0] = 32'hFFFF_FFFD;
        av[1] = 32'd7;         bv[1] = 32'd2; ov[1] = 4'd4; eh[1] = 32'd1;         el[1] = 32'd3;
        for (int k = 0; k < 2; k++) begin
            MDOp = ov[k]; A = av[k]; B = bv[k];
            #1;
            vectors++;
            if (Start !== 1'b1) begin
                miscompares++;
                $display("FAIL div%0d_start: start=%b need 1", k, Start);
            end
            tick();
            MDOp = 4'd0;
            repeat (9) tick();
            vectors++;
            if (Busy !== 1'b1) begin
                miscompares++;
                $display("FAIL div%0d_c10: busy=%b need 1", k, Busy);
            end
            tick();
            vectors++;
            if (Busy !== 1'b0 || HI !== eh[k] || LO !== el[k]) begin
                miscompares++;
                $display("FAIL div%0d_done: busy=%b hi=%h lo=%h, need 0/%h/%h", k, Busy, HI, LO, eh[k], el[k]);
            end
        end
    endtask

    task automatic test_move_divzero();
        MDOp = 4'd7; A = 32'h1234;
        tick();
        MDOp = 4'd8; A = 32'h5678;
        #1;
        vectors++;
        if (HI !== 32'h1234) begin
            miscompares++;
            $display("FAIL mthi: hi=%h need 00001234", HI);
        end
        tick();
        vectors++;
        if (LO !== 32'h5678) begin
            miscompares++;
            $display("FAIL mtlo: lo=%h need 00005678", LO);
        end
        MDOp = 4'd4; A = 32'd99; B = 32'd0;
        tick();
        MDOp = 4'd0;
        for (int i = 1; i <= 10; i++) begin
            vectors++;
            if (Busy !== 1'b1) begin
                miscompares++;
                $display("FAIL divzero_busy c%0d: busy=%b need 1", i, Busy);
            end
            tick();
        end
        MDOp = 4'd5;
        #1;
        vectors++;
        if (Busy !== 1'b0 || HI !== 32'h1234 || LO !== 32'h5678 || MDOut !== 32'h1234) begin
            miscompares++;
            $display("FAIL divzero_done: busy=%b hi=%h lo=%h mdout=%h, need 0/1234/5678/1234",
                     Busy, HI, LO, MDOut);
        end
        MDOp = 4'd9;
        #1;
        vectors++;
        if (MDOut !== 32'd0) begin
            miscompares++;
            $display("FAIL mdout_op9: mdout=%h need 0", MDOut);
        end
    endtask

    task automatic test_back_to_back();
        MDOp = 4'd1; A = 32'h0001_0000; B = 32'h0003_0000;
        tick();
        MDOp = 4'd0;
        tick();
        // cycle 2: mthi and a mfhi read while busy
        MDOp = 4'd7; A = 32'hAAAA;
        #1;
        vectors++;
        if (Start !== 1'b0 || MDOut !== 32'd0) begin
            miscompares++;
            $display("FAIL guard_c2: start=%b mdout=%h, need 0/0", Start, MDOut);
        end
        tick();
        // cycle 3: new mult with changed operands must be refused
        MDOp = 4'd2; A = 32'hFFFF; B = 32'hFFFF;
        #1;
        vectors++;
        if (Start !== 1'b0 || HI !== 32'h1234) begin
            miscompares++;
            $display("FAIL guard_c3: start=%b hi=%h, need 0/00001234", Start, HI);
        end
        tick();
        MDOp = 4'd0;
        repeat (2) tick();
        // cycle 6: result visible, next op accepted straight away
        MDOp = 4'd2; A = 32'd7; B = 32'd6;
        #1;
        vectors++;
        if (Busy !== 1'b0 || HI !== 32'd3 || LO !== 32'd0 || Start !== 1'b1) begin
            miscompares++;
            $display("FAIL b2b_first: busy=%b hi=%h lo=%h start=%b, need 0/3/0/1", Busy, HI, LO, Start);
        end
        tick();
        MDOp = 4'd0;
        repeat (5) tick();
        vectors++;
        if (Busy !== 1'b0 || HI !== 32'd0 || LO !== 32'd42) begin
            miscompares++;
            $display("FAIL b2b_second: busy=%b hi=%h lo=%h, need 0/0/2a", Busy, HI, LO);
        end
    endtask

    task automatic test_reset_abort();
        MDOp = 4'd3; A = 32'd100; B = 32'd7;
        tick();
        MDOp = 4'd0;
        repeat (3) tick();
        #2;
        reset = 1'b1;
        #1;
        vectors++;
        if (Busy !== 1'b0 || HI !== 32'd0 || LO !== 32'd0) begin
            miscompares++;
            $display("FAIL abort_async: busy=%b hi=%h lo=%h, need 0/0/0", Busy, HI, LO);
        end
        tick();
        reset = 1'b0;
        MDOp = 4'd1; A = 32'd6; B = 32'd7;
        #1;
        vectors++;
        if (Start !== 1'b1) begin
            miscompares++;
            $display("FAIL abort_restart: start=%b need 1", Start);
        end
        tick();
        MDOp = 4'd0;
        for (int i = 1; i <= 5; i++) begin
            vectors++;
            if (Busy !== 1'b1 || HI !== 32'd0 || LO !== 32'd0) begin
                miscompares++;
                $display("FAIL abort_busy c%0d: busy=%b hi=%h lo=%h, need 1/0/0", i, Busy, HI, LO);
            end
            tick();
        end
        vectors++;
        if (Busy !== 1'b0 || HI !== 32'd0 || LO !== 32'd42) begin
            miscompares++;
            $display("FAIL abort_done: busy=%b hi=%h lo=%h, need 0/0/2a", Busy, HI, LO);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        test_reset();
        test_mult();
        test_multu();
        test_div();
        test_move_divzero();
        test_back_to_back();
        test_reset_abort();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
